// File: rtl/line_buffer_ctrl.sv
// Line-buffer sequencer for streaming binary-image window filters.
// Drives a bank of Lines single-bit RAMs (registered write address/enable,
// 1-cycle read latency). It rotates the write target per row and realigns
// the read data into a vertical column of Lines+1 pixels.
module line_buffer_ctrl #(
  parameter int AddrWidth   = 10,
  parameter int ImageWidth  = 640,
  parameter int ImageHeight = 480,
  parameter int RowWidth    = 9,
  parameter int Lines       = 2
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 FrameStart,
  input  logic                 PixelValid,
  input  logic                 PixelIn,
  output logic [AddrWidth-1:0] RamAddr,
  output logic [Lines-1:0]     RamWriteEnable,
  output logic                 RamDataIn,
  input  logic [Lines-1:0]     RamDataOut,
  output logic                 ColValid,
  output logic [Lines:0]       ColOut,
  output logic [AddrWidth-1:0] Col,
  output logic [RowWidth-1:0]  Row,
  output logic                 LineEnd,
  output logic                 FrameEnd
);

  localparam int SelWidth = (Lines > 1) ? $clog2(Lines) : 1;
  localparam logic [AddrWidth-1:0] LastCol = AddrWidth'(ImageWidth - 1);
  localparam logic [RowWidth-1:0]  LastRow = RowWidth'(ImageHeight - 1);
  localparam logic [SelWidth-1:0]  LastSel = SelWidth'(Lines - 1);
  localparam logic [Lines-1:0]     SelOne  = {{(Lines-1){1'b0}}, 1'b1};

  typedef enum logic {StIdle = 1'b0, StActive = 1'b1} state_t;

  state_t               state;
  logic [AddrWidth-1:0] colCnt;
  logic [RowWidth-1:0]  rowCnt;
  logic [SelWidth-1:0]  wrSel;
  logic [SelWidth-1:0]  selD;     // write target of the pixel now on ColOut
  logic                 pixelD;   // pixel now on ColOut

  logic                 accept;
  logic                 lastCol;
  logic                 lastRow;
  logic [AddrWidth-1:0] curCol;
  logic [RowWidth-1:0]  curRow;
  logic [SelWidth-1:0]  curSel;
  logic [SelWidth-1:0]  nextSel;

  // Current pixel position; a FrameStart pulse overrides the counters so a
  // same-cycle pixel lands at (0,0) in line buffer 0.
  always_comb begin
    accept = nReset && PixelValid && (FrameStart || (state == StActive));
    if (FrameStart) begin
      curCol = {AddrWidth{1'b0}};
      curRow = {RowWidth{1'b0}};
      curSel = {SelWidth{1'b0}};
    end else begin
      curCol = colCnt;
      curRow = rowCnt;
      curSel = wrSel;
    end
    lastCol = (curCol == LastCol);
    lastRow = (curRow == LastRow);
    if (curSel == LastSel) begin
      nextSel = {SelWidth{1'b0}};
    end else begin
      nextSel = curSel + 1'b1;
    end
  end

  assign RamAddr        = curCol;
  assign RamWriteEnable = accept ? (SelOne << curSel) : {Lines{1'b0}};

  // Frame sequencing FSM with counters, write-target rotation and the
  // registered column metadata that accompanies the RAM read data.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= StIdle;
      colCnt    <= {AddrWidth{1'b0}};
      rowCnt    <= {RowWidth{1'b0}};
      wrSel     <= {SelWidth{1'b0}};
      selD      <= {SelWidth{1'b0}};
      pixelD    <= 1'b0;
      RamDataIn <= 1'b0;
      ColValid  <= 1'b0;
      Col       <= {AddrWidth{1'b0}};
      Row       <= {RowWidth{1'b0}};
      LineEnd   <= 1'b0;
      FrameEnd  <= 1'b0;
    end else begin
      RamDataIn <= PixelIn;
      ColValid  <= accept;
      LineEnd   <= accept && lastCol;
      FrameEnd  <= accept && lastCol && lastRow;
      if (accept) begin
        pixelD <= PixelIn;
        selD   <= curSel;
        Col    <= curCol;
        Row    <= curRow;
        if (lastCol && lastRow) begin
          state  <= StIdle;
          colCnt <= {AddrWidth{1'b0}};
          rowCnt <= {RowWidth{1'b0}};
          wrSel  <= nextSel;
        end else if (lastCol) begin
          state  <= StActive;
          colCnt <= {AddrWidth{1'b0}};
          rowCnt <= curRow + 1'b1;
          wrSel  <= nextSel;
        end else begin
          state  <= StActive;
          colCnt <= curCol + 1'b1;
          rowCnt <= curRow;
          wrSel  <= curSel;
        end
      end else if (FrameStart) begin
        pixelD <= 1'b0;
        state  <= StActive;
        colCnt <= {AddrWidth{1'b0}};
        rowCnt <= {RowWidth{1'b0}};
        wrSel  <= {SelWidth{1'b0}};
      end else begin
        pixelD <= 1'b0;
      end
    end
  end

  assign ColOut[0] = pixelD;

  // Tap k reads the buffer written k rows ago; rows above the frame top are
  // forced to 0 so stale or power-up RAM contents never reach the window.
  for (genvar k = 1; k <= Lines; k++) begin : gTap
    logic [SelWidth-1:0] srcSel;
    assign srcSel    = SelWidth'((int'(selD) + Lines - k) % Lines);
    assign ColOut[k] = (ColValid && (Row >= RowWidth'(k))) ? RamDataOut[srcSel] : 1'b0;
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl: a small RAM bank model, a
// frame-level reference model (image array indexed by row/column) and
// directed plus randomized stimulus.
module tb_line_buffer_ctrl;

  localparam int W = 4;
  localparam int H = 3;
  localparam int L = 2;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic       FrameStart = 1'b0;
  logic       PixelValid = 1'b0;
  logic       PixelIn = 1'b0;
  logic [1:0] RamAddr;
  logic [1:0] RamWriteEnable;
  logic       RamDataIn;
  logic [1:0] RamDataOut;
  logic       ColValid;
  logic [2:0] ColOut;
  logic [1:0] Col;
  logic [1:0] Row;
  logic       LineEnd;
  logic       FrameEnd;

  line_buffer_ctrl #(
    .AddrWidth(2), .ImageWidth(W), .ImageHeight(H), .RowWidth(2), .Lines(L)
  ) dut (
    .Clock(Clock), .nReset(nReset), .FrameStart(FrameStart),
    .PixelValid(PixelValid), .PixelIn(PixelIn), .RamAddr(RamAddr),
    .RamWriteEnable(RamWriteEnable), .RamDataIn(RamDataIn),
    .RamDataOut(RamDataOut), .ColValid(ColValid), .ColOut(ColOut),
    .Col(Col), .Row(Row), .LineEnd(LineEnd), .FrameEnd(FrameEnd)
  );

  always #5 Clock = ~Clock;

  // RAM bank: address/enable registered, data written one cycle later,
  // synchronous read (old contents returned on a same-cycle write).
  logic       mem [L][W];
  logic [1:0] rdData = 2'b00;
  logic [1:0] weD = 2'b00;
  logic [1:0] addrD = 2'b00;
  assign RamDataOut = rdData;

  always @(posedge Clock) begin
    for (int i = 0; i < L; i++) begin
      rdData[i] <= mem[i][RamAddr];
      if (weD[i]) mem[i][addrD] <= RamDataIn;
    end
    weD   <= RamWriteEnable;
    addrD <= RamAddr;
  end

  // Reference model state
  bit         mActive = 1'b0;
  int         mCol = 0;
  int         mRow = 0;
  logic       img [H][W];
  logic       eValid = 1'b0, eLineEnd = 1'b0, eFrameEnd = 1'b0, eDataIn = 1'b0;
  logic [2:0] eColOut = 3'b000;
  int         eCol = 0, eRow = 0;
  logic [2:0] obs  [4][4];
  logic [2:0] mObs [4][4];
  logic [3:0] winRows [H];

  int nCmp = 0;
  int nFail = 0;
  int cvCnt = 0, leCnt = 0, feCnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outputs are compared mid-cycle against the model.
  task automatic compare();
    logic       acc;
    int         sel;
    logic [1:0] expWe;
    if (!nReset) begin
      chk("rst_addr", RamAddr, 0);
      chk("rst_we", RamWriteEnable, 0);
      chk("rst_din", RamDataIn, 0);
      chk("rst_valid", ColValid, 0);
      chk("rst_colout", ColOut, 0);
      chk("rst_col", Col, 0);
      chk("rst_row", Row, 0);
      chk("rst_lineend", LineEnd, 0);
      chk("rst_frameend", FrameEnd, 0);
    end else begin
      acc   = PixelValid && (mActive || FrameStart);
      sel   = FrameStart ? 0 : (mRow % L);
      expWe = acc ? (2'b01 << sel) : 2'b00;
      chk("ram_addr", RamAddr, FrameStart ? 0 : mCol);
      chk("ram_we", RamWriteEnable, expWe);
      chk("ram_din", RamDataIn, eDataIn);
      chk("col_valid", ColValid, eValid);
      chk("line_end", LineEnd, eLineEnd);
      chk("frame_end", FrameEnd, eFrameEnd);
      if (eValid) begin
        chk("col_out", ColOut, eColOut);
        chk("col", Col, eCol);
        chk("row", Row, eRow);
      end
      if (ColValid) begin
        cvCnt++;
        obs[Row][Col] = ColOut;
      end
      if (LineEnd) leCnt++;
      if (FrameEnd) feCnt++;
    end
  endtask

  // Frame-level model: each accepted pixel goes into img; the window column
  // is the pixel plus the same column of the k previous rows of this frame.
  task automatic modelUpdate();
    logic acc;
    if (!nReset) begin
      mActive = 1'b0; mCol = 0; mRow = 0;
      eValid = 1'b0; eLineEnd = 1'b0; eFrameEnd = 1'b0; eDataIn = 1'b0;
      eColOut = 3'b000; eCol = 0; eRow = 0;
      return;
    end
    eDataIn = PixelIn;
    if (FrameStart) begin
      mActive = 1'b1; mCol = 0; mRow = 0;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 1'b0;
    end
    acc       = PixelValid && mActive;
    eValid    = acc;
    eLineEnd  = acc && (mCol == W - 1);
    eFrameEnd = eLineEnd && (mRow == H - 1);
    if (acc) begin
      img[mRow][mCol] = PixelIn;
      eColOut    = 3'b000;
      eColOut[0] = PixelIn;
      for (int k = 1; k <= L; k++) if (k <= mRow) eColOut[k] = img[mRow-k][mCol];
      eCol = mCol;
      eRow = mRow;
      mObs[mRow][mCol] = eColOut;
      if (mCol == W - 1) begin
        mCol = 0;
        if (mRow == H - 1) begin
          mRow = 0;
          mActive = 1'b0;
        end else begin
          mRow++;
        end
      end else begin
        mCol++;
      end
    end
  endtask

  task automatic tail();
    @(posedge Clock);
    modelUpdate();
    #1;
  endtask

  task automatic step(input logic fs, input logic pv, input logic px);
    FrameStart = fs;
    PixelValid = pv;
    PixelIn    = px;
    @(negedge Clock);
    compare();
    tail();
  endtask

  task automatic runFrame(input int mode, input int npix);
    for (int i = 0; i < npix; i++) begin
      int r, c;
      logic px;
      r  = i / W;
      c  = i % W;
      px = (mode == 0) ? winRows[r][W-1-c] : 1'b0;
      step(i == 0, 1'b1, px);
    end
    if (npix == W * H) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic clearCounts();
    cvCnt = 0; leCnt = 0; feCnt = 0;
  endtask

  task automatic checkPins(input string tag);
    chk({tag, "_r2c0"}, obs[2][0], 3'b101);
    chk({tag, "_r2c1"}, obs[2][1], 3'b011);
    chk({tag, "_r1c0"}, obs[1][0], 3'b010);
    chk({tag, "_model_r2c0"}, mObs[2][0], 3'b101);
    chk({tag, "_model_r2c1"}, mObs[2][1], 3'b011);
    chk({tag, "_model_r1c0"}, mObs[1][0], 3'b010);
    for (int c = 0; c < W; c++) chk({tag, "_r0_pad"}, obs[0][c][2:1], 2'b00);
    chk({tag, "_valids"}, cvCnt, 12);
    chk({tag, "_lineends"}, leCnt, 3);
    chk({tag, "_frameends"}, feCnt, 1);
  endtask

  initial begin
    winRows[0] = 4'b1010;
    winRows[1] = 4'b0110;
    winRows[2] = 4'b1111;
    for (int i = 0; i < L; i++) for (int c = 0; c < W; c++) mem[i][c] = 1'($urandom);

    @(posedge Clock);
    #1;
    // Reset held, then idle with PixelValid but no FrameStart
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    nReset = 1'b1;
    clearCounts();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    chk("idle_valids", cvCnt, 0);

    // Clean window frame, then idle ignores pixels
    clearCounts();
    runFrame(0, W * H);
    checkPins("frame1");
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);

    // All-zero frame: no stale data from the previous frame
    clearCounts();
    runFrame(1, W * H);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) chk("zero_frame", obs[r][c], 3'b000);

    // Gapped stream 1,0,0,1,1
    step(1'b1, 1'b0, 1'b0);
    clearCounts();
    step(1'b0, 1'b1, 1'($urandom));
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'($urandom));
    step(1'b0, 1'b1, 1'($urandom));
    step(1'b0, 1'b0, 1'b0);
    chk("gap_pulses", cvCnt, 3);
    chk("gap_addr", RamAddr, 3);

    // Restart with FrameStart+PixelValid at row1 col2
    runFrame(0, 6);
    FrameStart = 1'b1; PixelValid = 1'b1; PixelIn = 1'b1;
    @(negedge Clock);
    compare();
    chk("restart_we", RamWriteEnable, 2'b01);
    chk("restart_addr", RamAddr, 0);
    tail();
    chk("restart_valid", ColValid, 1);
    chk("restart_col", Col, 0);
    chk("restart_row", Row, 0);
    chk("restart_pad", ColOut[2:1], 2'b00);
    for (int i = 1; i < W * H; i++) step(1'b0, 1'b1, 1'($urandom));
    step(1'b0, 1'b0, 1'b0);

    // Reset at row2 col1, then a clean frame
    runFrame(0, 9);
    nReset = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    nReset = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    clearCounts();
    runFrame(0, W * H);
    checkPins("after_reset");

    // Randomized stream with gaps, restarts and occasional resets
    for (int n = 0; n < 2000; n++) begin
      logic fs, pv, px;
      fs = mActive ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 7) == 0);
      pv = ($urandom_range(0, 3) != 0);
      px = 1'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        nReset = 1'b0;
        step(1'b0, pv, px);
        nReset = 1'b1;
      end else begin
        step(fs, pv, px);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
